// File: rtl/gesture_scan_controller.sv
// Raster-scan gesture classifier: one HSV pixel per clock, green filter,
// left-half green count and strip transitions, then rock/paper/scissors.
module gesture_scan_controller #(
    parameter int HEIGHT               = 4,
    parameter int LENGTH               = 4,
    parameter int SUM_THRESHOLD        = 1200,
    parameter int SCISSORS_TRANSITIONS = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [2:0][7:0]             lower_green,
    input  logic [2:0][7:0]             upper_green,
    output logic                        pix_rd_en,
    output logic [$clog2(HEIGHT)-1:0]   pix_row,
    output logic [$clog2(LENGTH)-1:0]   pix_col,
    input  logic [2:0][7:0]             pix_data,
    output logic                        busy,
    output logic [1:0]                  result,
    output logic                        result_valid,
    input  logic                        result_ready,
    output logic [31:0]                 sum_left,
    output logic [7:0]                  transitions
);

    localparam int RW = $clog2(HEIGHT);
    localparam int CW = $clog2(LENGTH);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(LENGTH - 1);
    localparam logic [CW-1:0] HALF_COL = CW'(LENGTH / 2);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DRAIN,
        DECIDE,
        HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [CW-1:0]   dcol_q, dcol_d;
    logic            vld_q, vld_d;
    logic [2:0][7:0] lo_q, lo_d;
    logic [2:0][7:0] hi_q, hi_d;
    logic [31:0]     sum_q, sum_d;
    logic [7:0]      trans_q, trans_d;
    logic            prev_q, prev_d;
    logic [1:0]      result_q, result_d;
    logic            green;

    // Pixel classification against the latched inclusive bounds.
    always_comb begin
        green = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (pix_data[c] < lo_q[c] || pix_data[c] > hi_q[c]) begin
                green = 1'b0;
            end
        end
    end

    // Next-state, address sequencing and statistics accumulation.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        sum_d     = sum_q;
        trans_d   = trans_q;
        prev_d    = prev_q;
        result_d  = result_q;
        pix_rd_en = 1'b0;
        vld_d     = (state_q == SCAN);
        dcol_d    = col_q;

        // Data returned for the read issued last cycle.
        if (vld_q) begin
            if (green && dcol_q < HALF_COL) begin
                sum_d = sum_q + 32'd1;
            end
            if (dcol_q == HALF_COL) begin
                if (green != prev_q && trans_q != 8'hFF) begin
                    trans_d = trans_q + 8'd1;
                end
                prev_d = green;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    lo_d    = lower_green;
                    hi_d    = upper_green;
                    sum_d   = 32'd0;
                    trans_d = 8'd0;
                    prev_d  = 1'b0;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                pix_rd_en = 1'b1;
                if (row_q == ROW_LAST && col_q == COL_LAST) begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = DRAIN;
                end else if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            DRAIN: begin
                state_d = DECIDE;
            end
            DECIDE: begin
                if (trans_q == 8'(SCISSORS_TRANSITIONS)) begin
                    result_d = 2'd2;
                end else if (sum_q > 32'(SUM_THRESHOLD)) begin
                    result_d = 2'd1;
                end else begin
                    result_d = 2'd0;
                end
                state_d = HOLD;
            end
            HOLD: begin
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; reset also drops any read in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_q    <= '0;
            col_q    <= '0;
            dcol_q   <= '0;
            vld_q    <= 1'b0;
            lo_q     <= '0;
            hi_q     <= '0;
            sum_q    <= 32'd0;
            trans_q  <= 8'd0;
            prev_q   <= 1'b0;
            result_q <= 2'd0;
        end else begin
            row_q    <= row_d;
            col_q    <= col_d;
            dcol_q   <= dcol_d;
            vld_q    <= vld_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            sum_q    <= sum_d;
            trans_q  <= trans_d;
            prev_q   <= prev_d;
            result_q <= result_d;
        end
    end

    assign pix_row      = row_q;
    assign pix_col      = col_q;
    assign busy         = (state_q != IDLE);
    assign result_valid = (state_q == HOLD);
    assign result       = result_q;
    assign sum_left     = sum_q;
    assign transitions  = trans_q;

endmodule

// File: tb/tb_gesture_scan_controller.sv
// Bench for gesture_scan_controller: frame-level reference model checked
// every cycle, plus literal expectations for each directed frame.
module tb_gesture_scan_controller;

    localparam int H  = 4;
    localparam int L  = 4;
    localparam int N  = H * L;
    localparam int TH = 3;
    localparam int SC = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [2:0][7:0] lower_green = '0;
    logic [2:0][7:0] upper_green = '0;
    logic            pix_rd_en;
    logic [1:0]      pix_row;
    logic [1:0]      pix_col;
    logic [2:0][7:0] pix_data = '0;
    logic            busy;
    logic [1:0]      result;
    logic            result_valid;
    logic            result_ready = 1'b0;
    logic [31:0]     sum_left;
    logic [7:0]      transitions;

    gesture_scan_controller #(
        .HEIGHT(H), .LENGTH(L),
        .SUM_THRESHOLD(TH), .SCISSORS_TRANSITIONS(SC)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .lower_green(lower_green), .upper_green(upper_green),
        .pix_rd_en(pix_rd_en), .pix_row(pix_row), .pix_col(pix_col),
        .pix_data(pix_data), .busy(busy), .result(result),
        .result_valid(result_valid), .result_ready(result_ready),
        .sum_left(sum_left), .transitions(transitions)
    );

    always #5 clk = ~clk;

    logic [2:0][7:0] frame [H][L];

    // Frame buffer: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (pix_rd_en) pix_data <= frame[pix_row][pix_col];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Frame-level reference: statistics straight from the frame contents.
    function automatic void eval_frame(input logic [2:0][7:0] lo,
                                       input logic [2:0][7:0] hi,
                                       output int s, output int t,
                                       output int r);
        bit prev = 0;
        bit g;
        s = 0;
        t = 0;
        for (int rr = 0; rr < H; rr++) begin
            for (int cc = 0; cc < L; cc++) begin
                g = 1;
                for (int k = 0; k < 3; k++)
                    if (frame[rr][cc][k] < lo[k] || frame[rr][cc][k] > hi[k])
                        g = 0;
                if (g && cc < L / 2) s++;
                if (cc == L / 2) begin
                    if (g != prev && t < 255) t++;
                    prev = g;
                end
            end
        end
        r = (t == SC) ? 2 : (s > TH) ? 1 : 0;
    endfunction

    bit m_started = 0;
    bit m_idle = 1;
    bit m_hold = 0;
    int m_k = 0;
    int m_sum = 0, m_tr = 0, m_res = 0;
    int p_sum = 0, p_tr = 0, p_res = 0;

    // Model timeline: cycle index since the accepted start.
    always @(posedge clk) begin
        m_started = 1;
        if (reset) begin
            m_idle = 1; m_hold = 0; m_k = 0;
            m_sum = 0; m_tr = 0; m_res = 0;
        end else if (m_idle) begin
            if (start) begin
                eval_frame(lower_green, upper_green, p_sum, p_tr, p_res);
                m_idle = 0; m_k = 1;
            end
        end else if (m_hold) begin
            if (result_ready) begin
                m_idle = 1; m_hold = 0;
            end
        end else begin
            m_k++;
            if (m_k == N + 3) begin
                m_hold = 1;
                m_sum = p_sum; m_tr = p_tr; m_res = p_res;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        bit exp_rd;
        if (m_started) begin
            exp_rd = !m_idle && !m_hold && m_k >= 1 && m_k <= N;
            chk("rd_en", int'(pix_rd_en), int'(exp_rd));
            chk("busy", int'(busy), int'(!m_idle));
            chk("result_valid", int'(result_valid), int'(m_hold));
            if (exp_rd && pix_rd_en) begin
                chk("pix_row", int'(pix_row), (m_k - 1) / L);
                chk("pix_col", int'(pix_col), (m_k - 1) % L);
            end
            if (m_hold) begin
                chk("hold_result", int'(result), m_res);
                chk("hold_sum", int'(sum_left), m_sum);
                chk("hold_trans", int'(transitions), m_tr);
            end
        end
    end

    logic [2:0][7:0] lo_ok, hi_ok;
    logic [2:0][7:0] pg, pb;

    task automatic fill(input logic [2:0][7:0] v);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < L; c++)
                frame[r][c] = v;
    endtask

    // Start at the current negedge; wait for result, then hand it off.
    task automatic run_scan(input int hold_cyc, input bit mid_start,
                            output int rise, output int r_res,
                            output int r_sum, output int r_tr);
        int c;
        start = 1;
        @(negedge clk);
        start = 0;
        c = 1;
        while (!result_valid && c < 40) begin
            if (mid_start && c == 5) begin
                start = 1;
                lower_green = hi_ok;
                upper_green = lo_ok;
            end else if (mid_start && c == 6) begin
                start = 0;
            end
            @(negedge clk);
            c++;
        end
        start = 0;
        lower_green = lo_ok;
        upper_green = hi_ok;
        if (!result_valid) begin
            errors++;
            checks++;
            $display("FAIL result_valid timeout: got 0 expected 1");
        end
        rise = c;
        r_res = int'(result);
        r_sum = int'(sum_left);
        r_tr  = int'(transitions);
        repeat (hold_cyc) @(negedge clk);
        result_ready = 1;
        @(negedge clk);
    endtask

    int rise, rr, rs, rt;
    int c0;

    initial begin
        lo_ok = '0; hi_ok = '0;
        lo_ok[0] = 8'd36; lo_ok[1] = 8'd25;  lo_ok[2] = 8'd25;
        hi_ok[0] = 8'd86; hi_ok[1] = 8'd255; hi_ok[2] = 8'd255;
        pg = '0; pg[0] = 8'd50; pg[1] = 8'd100; pg[2] = 8'd100;
        pb = '0;
        lower_green = lo_ok;
        upper_green = hi_ok;
        fill(pg);

        repeat (2) @(negedge clk);
        reset = 0;
        chk("rst_rd_en", int'(pix_rd_en), 0);
        chk("rst_row", int'(pix_row), 0);
        chk("rst_col", int'(pix_col), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_valid", int'(result_valid), 0);
        chk("rst_sum", int'(sum_left), 0);
        chk("rst_trans", int'(transitions), 0);
        repeat (20) @(negedge clk);

        // Scissors: strip column rows 1 and 3 black.
        frame[1][L/2] = pb;
        frame[3][L/2] = pb;
        result_ready = 0;
        run_scan(0, 0, rise, rr, rs, rt);
        result_ready = 0;
        chk("sc_rise", rise, 19);
        chk("sc_result", rr, 2);
        chk("sc_trans", rt, 4);
        chk("sc_sum", rs, 8);

        // Paper with 10 cycles of backpressure.
        fill(pg);
        run_scan(10, 0, rise, rr, rs, rt);
        result_ready = 0;
        chk("pa_result", rr, 1);
        chk("pa_sum", rs, 8);
        chk("pa_trans", rt, 1);
        chk("pa_idle", int'(busy), 0);

        // Reuse, with a start pulse and bound change mid-scan.
        run_scan(3, 1, rise, rr, rs, rt);
        result_ready = 0;
        chk("re_result", rr, 1);
        chk("re_sum", rs, 8);
        chk("re_trans", rt, 1);

        // Rock.
        fill(pb);
        run_scan(0, 0, rise, rr, rs, rt);
        result_ready = 0;
        chk("ro_result", rr, 0);
        chk("ro_sum", rs, 0);
        chk("ro_trans", rt, 0);

        // Inverted bounds: nothing is green.
        fill(pg);
        lo_ok = hi_ok;
        hi_ok[0] = 8'd36; hi_ok[1] = 8'd25; hi_ok[2] = 8'd25;
        lower_green = lo_ok;
        upper_green = hi_ok;
        run_scan(0, 0, rise, rr, rs, rt);
        chk("inv_result", rr, 0);
        chk("inv_sum", rs, 0);
        hi_ok = lo_ok;
        lo_ok[0] = 8'd36; lo_ok[1] = 8'd25; lo_ok[2] = 8'd25;
        lower_green = lo_ok;
        upper_green = hi_ok;

        // Back-to-back frames with ready tied high.
        result_ready = 1;
        run_scan(0, 0, rise, rr, rs, rt);
        chk("bb1_rise", rise, 19);
        run_scan(0, 0, rise, rr, rs, rt);
        chk("bb2_rise", rise, 19);
        chk("bb2_result", rr, 1);
        result_ready = 0;

        // Reset in cycle 7 of a scan.
        start = 1;
        @(negedge clk);
        start = 0;
        c0 = 1;
        while (c0 < 7) begin
            @(negedge clk);
            c0++;
        end
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("mr_busy", int'(busy), 0);
        chk("mr_rd_en", int'(pix_rd_en), 0);
        chk("mr_sum", int'(sum_left), 0);
        chk("mr_trans", int'(transitions), 0);
        chk("mr_valid", int'(result_valid), 0);
        @(negedge clk);
        frame[1][L/2] = pb;
        frame[3][L/2] = pb;
        run_scan(0, 0, rise, rr, rs, rt);
        result_ready = 0;
        chk("mr2_result", rr, 2);
        chk("mr2_trans", rt, 4);
        chk("mr2_rise", rise, 19);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gesture_scan_controller.md
# gesture_scan_controller

Sequential controller that runs the rock/paper/scissors gesture classifier over a stored HSV frame, one pixel per clock. It reads pixels from the frame buffer in raster order, applies the green HSV filter, and accumulates two statistics: the green-pixel count in the left half and the green/non-green transition count down a fixed vertical strip. When the scan finishes it produces a classification with a valid/ready handshake. It sits between the camera frame buffer and the gesture result consumer (display/LED logic).

## Interface
- HEIGHT, from global_params.vh: frame rows.
- LENGTH, from global_params.vh: frame columns.
- STRIP_COL, LENGTH/2: column scanned for transitions.
- SUM_THRESHOLD, 1200: left-half green count above which the result is paper.
- SCISSORS_TRANSITIONS, 4: exact transition count classified as scissors.

Ports:
- clk  in  1: clock.
- reset  in  1: synchronous, active-high reset.
- start  in  1: begin a scan; sampled only in IDLE.
- lower_green  in  [2:0][7:0]: inclusive lower HSV bound; latched on accepted start.
- upper_green  in  [2:0][7:0]: inclusive upper HSV bound; latched on accepted start.
- pix_rd_en  out  1: frame buffer read strobe.
- pix_row  out  $clog2(HEIGHT): read row address.
- pix_col  out  $clog2(LENGTH): read column address.
- pix_data  in  [2:0][7:0]: HSV pixel; valid exactly 1 cycle after pix_rd_en.
- busy  out  1: high in every state except IDLE.
- result  out  [1:0]: 0 = rock, 1 = paper, 2 = scissors.
- result_valid  out  1: result available.
- result_ready  in  1: consumer accepts result.
- sum_left  out  32: left-half green count. Held with result.
- transitions  out  8: strip transition count. Held with result.

## Operation
- FSM states: IDLE, SCAN, DRAIN, DECIDE, HOLD.
- IDLE:
  - start=1 latches the bounds, clears the counters, zeroes row/col, prev_bit=0, and goes to SCAN.
- SCAN:
  - pix_rd_en=1 every cycle.
  - Address advances col-first: col wraps at LENGTH-1 to 0 and row increments.
  - After issuing (HEIGHT-1, LENGTH-1), go to DRAIN.
- DRAIN: one cycle. The last pixel is processed. pix_rd_en=0.
- DECIDE: one cycle; registers result:
  - 2 if transitions == SCISSORS_TRANSITIONS;
  - else 1 if sum_left > SUM_THRESHOLD (unsigned, strict);
  - else 0.
- HOLD:
  - result_valid=1; result, sum_left and transitions are stable.
  - On result_valid & result_ready, go to IDLE.
- Pixel processing happens in the cycle pix_data is valid, using a delayed copy of the address:
  - green = 1 iff lower_green[c] <= pix_data[c] <= upper_green[c] for all c in 0..2.
  - sum_left increments if green and col < LENGTH/2. It is 32 bits and does not wrap for any legal frame size.
  - For col == STRIP_COL: transitions increments if green != prev_bit, then prev_bit is set to green. prev_bit starts at 0, so a green row 0 counts as one transition. transitions saturates at 255.
- If lower > upper in any channel, no pixel is green and the result is 0.
- start is ignored outside IDLE. Changes to lower_green/upper_green during a scan are ignored.
- reset, in any state including mid-scan or HOLD: next state IDLE, and every output and counter returns to its reset value. Any read in flight is discarded.

## Timing
- Reset values:
  - pix_rd_en=0, pix_row=0, pix_col=0, busy=0.
  - result=0, result_valid=0, sum_left=0, transitions=0.
- Let N = HEIGHT*LENGTH, and cycle 0 be the cycle start=1 is sampled in IDLE.
  - Reads are issued in cycles 1..N.
  - DRAIN is cycle N+1, DECIDE is cycle N+2.
  - result_valid rises at cycle N+3.
- busy rises at cycle 1 and falls the cycle after the handshake.
- result_ready already high when result_valid rises: transfer completes at N+3, IDLE at N+4. A new start is accepted at N+4, with its first read at N+5.
- result_ready held low: HOLD persists indefinitely with outputs stable.
- Throughput: one frame per N+4 cycles with result_ready tied high.

## Test plan
- Reset then idle (HEIGHT=LENGTH=4, SUM_THRESHOLD=3): no start -> pix_rd_en=0, busy=0, result_valid=0 for 20 cycles.
- Scissors: all pixels (50,100,100) except strip-column rows 1 and 3 = (0,0,0), bounds {36,25,25}/{86,255,255} -> transitions=4, result=2, result_valid at cycle 19.
- Paper: whole frame green -> sum_left=8, transitions=1, result=1.
- Rock: whole frame (0,0,0) -> sum_left=0, transitions=0, result=0.
- Backpressure and reuse: result_ready low 10 cycles after valid -> outputs stable. Raise ready -> IDLE next cycle, then a second start reproduces identical results. A start pulsed mid-scan is ignored.
- Reset mid-scan at cycle 7 -> next cycle busy=0, pix_rd_en=0, counters 0. A subsequent full scan gives correct results.
